// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// The arbiter side uses the slave modport and the requester side uses the master modport.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a bounded hold time and a mandatory idle cycle after release.
// All outputs come straight from flops.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_8_if.slave bus
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [2:0] pick;
  logic [2:0] cand;

  // Rotating priority search: first requester at or above ptr, modulo 8.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    cand  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (found) begin
          state_d       = StBusy;
          grant_d       = 8'd1 << pick;
          grant_idx_d   = pick;
          grant_valid_d = 1'b1;
          cnt_d         = 8'd0;
        end
      end
      StBusy: begin
        // A falling owner request wins over the hold limit, so no timeout on a tie.
        if (!bus.req[grant_idx_q] || (cnt_q == HoldLast)) begin
          state_d       = StIdle;
          grant_d       = 8'd0;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 3'd1;
          cnt_d         = 8'd0;
          timeout_d     = bus.req[grant_idx_q];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d       = StIdle;
        grant_d       = 8'd0;
        grant_idx_d   = 3'd0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= 3'd0;
      cnt_q         <= 8'd0;
      grant_q       <= 8'd0;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with MAX_HOLD=4; expected values are hand-computed per step.
// A negedge monitor also checks the one-hot/encoding invariants every cycle.
module tb_rr_arbiter_8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic mon_en;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] enc8(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("onehot0", 32'($onehot0(bus.grant)), 32'd1);
      check_eq("idx_enc", 32'(bus.grant_idx), 32'(enc8(bus.grant)));
      check_eq("valid_or", 32'(bus.grant_valid), 32'(|bus.grant));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] r);
    rst_n   = 1'b0;
    bus.req = r;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic expect_grant(input string tag, input logic [2:0] idx);
    check_eq({tag, "_grant"}, 32'(bus.grant), 32'(8'd1 << idx));
    check_eq({tag, "_idx"}, 32'(bus.grant_idx), 32'(idx));
    check_eq({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    check_eq({tag, "_to"}, 32'(bus.timeout), 32'd0);
  endtask

  task automatic expect_idle(input string tag, input logic to);
    check_eq({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check_eq({tag, "_idx"}, 32'(bus.grant_idx), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.grant_valid), 32'd0);
    check_eq({tag, "_to"}, 32'(bus.timeout), 32'(to));
  endtask

  // Four cycles of ownership followed by one forced-release cycle.
  task automatic run_hold(input string tag, input logic [2:0] idx);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_grant(tag, idx);
    end
    tick();
    expect_idle({tag, "_rel"}, 1'b1);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    bus.req = 8'h00;

    // Reset state
    do_reset(8'hFF);
    mon_en = 1'b1;
    expect_idle("reset", 1'b0);

    // Single requester 0, then voluntary release
    bus.req = 8'h01;
    tick();
    expect_grant("single0", 3'd0);
    bus.req = 8'h00;
    tick();
    expect_idle("single0_rel", 1'b0);
    tick();
    expect_idle("idle_noreq", 1'b0);

    // All requesting, each owner drops for one cycle: 0..7,0 with idle gaps
    do_reset(8'hFF);
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_grant("rr_seq", 3'(k % 8));
      bus.req[k % 8] = 1'b0;
      tick();
      expect_idle("rr_gap", 1'b0);
      bus.req[k % 8] = 1'b1;
    end

    // Lone holder times out and is regranted
    do_reset(8'b0000_1000);
    run_hold("hold3", 3'd3);
    tick();
    expect_grant("hold3_again", 3'd3);

    // Timeout rotation with wrap: 2 -> 7 -> 2
    do_reset(8'b1000_0100);
    run_hold("to2", 3'd2);
    run_hold("to7", 3'd7);
    run_hold("to2_wrap", 3'd2);

    // Non-owner churn is ignored; owner drop on the limit edge is voluntary
    do_reset(8'b0000_1000);
    tick();
    expect_grant("churn_a", 3'd3);
    bus.req = 8'h7F;
    tick();
    expect_grant("churn_b", 3'd3);
    bus.req = 8'h0A;
    tick();
    expect_grant("churn_c", 3'd3);
    bus.req = 8'hFF;
    tick();
    expect_grant("churn_d", 3'd3);
    bus.req = 8'hF7;
    tick();
    expect_idle("tie_vol", 1'b0);
    tick();
    expect_grant("after_tie", 3'd4);

    // Reset during BUSY drops grant; arbitration restarts at ptr 0
    do_reset(8'h20);
    tick();
    expect_grant("own5", 3'd5);
    rst_n   = 1'b0;
    bus.req = 8'h30;
    tick();
    expect_idle("rst_busy", 1'b0);
    rst_n = 1'b1;
    tick();
    expect_grant("post_rst", 3'd4);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, shall set the maximum consecutive cycles one owner may hold the grant (legal range 2..255).
REQ-002 clk  input  1  shall be the single clock; all state shall update on the rising edge.
REQ-003 rst_n  input  1  shall be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  8  shall carry the request lines, one bit per requester 0..7, level-sensitive.
REQ-005 grant  output  8  shall be the registered one-hot grant, with at most one bit set.
REQ-006 grant_idx  output  3  shall be the registered binary index of the current owner, 3'd0 when idle.
REQ-007 grant_valid  output  1  shall be the registered flag, high exactly when grant is nonzero.
REQ-008 timeout  output  1  shall be a registered one-cycle pulse marking a forced release.

Function
REQ-009 The FSM shall have exactly two states: IDLE and BUSY.
REQ-010 In IDLE with req==0, the block shall stay in IDLE with grant=0, grant_valid=0 and grant_idx=0.
REQ-011 In IDLE with req!=0 at an edge, the block shall select the first set bit at or after pointer ptr, searching upward modulo 8, and enter BUSY.
REQ-012 In that case grant, grant_idx and grant_valid shall be visible in the cycle after the sampling edge (1-cycle latency).
REQ-013 grant_idx shall always equal the binary encoding of the one-hot grant, matching an 8-to-3 encoder.
REQ-014 In BUSY the grant shall hold while req[grant_idx]=1 and the hold counter is below MAX_HOLD-1.
REQ-015 The hold counter shall be 8 bits, load 0 on entry to BUSY, and increment every BUSY cycle.
REQ-016 Voluntary release: when req[grant_idx]=0 at an edge in BUSY, the block shall go to IDLE, clear grant/grant_valid on that edge, and set ptr=(grant_idx+1) mod 8.
REQ-017 Forced release: when the hold counter equals MAX_HOLD-1 and req[grant_idx]=1 at an edge, the block shall go to IDLE, clear the grant, and set ptr=(grant_idx+1) mod 8.
REQ-018 A forced release shall also pulse timeout high for exactly the following cycle.
REQ-019 Every release shall be followed by at least one cycle with grant_valid=0 before any new grant (no back-to-back handover).
REQ-020 ptr shall wrap from 7 to 0; after owner 7 is released, the search shall start at requester 0.
REQ-021 After a release, a sole remaining requester, including the previous owner, shall be granted again via the normal IDLE path.
REQ-022 Changes to non-owner req bits during BUSY shall not affect grant, the hold counter or ptr.
REQ-023 If req[grant_idx] falls on the same edge the counter reaches MAX_HOLD-1, the block shall treat it as a voluntary release with no timeout pulse.
REQ-024 grant shall never have more than one bit set in any cycle, including reset and release cycles.

Reset
REQ-025 With rst_n=0 at an edge, the block shall force state=IDLE, ptr=0, counter=0, grant=8'h00, grant_idx=3'd0, grant_valid=0 and timeout=0, regardless of req.
REQ-026 Reset asserted during BUSY shall drop the grant on that edge, with no timeout pulse.
REQ-027 On the first edge with rst_n=1, the block shall arbitrate from ptr=0.
REQ-028 All outputs shall be driven directly from registers, with no combinational path from req to any output.

Verification
REQ-029 Reset, then req=8'b0000_0001 held -> grant=8'h01, grant_idx=0, grant_valid=1 one cycle after the first sampling edge.
REQ-030 req=8'hFF from reset, each owner drops its req one cycle after being granted, then re-raises it -> grant_idx sequence 0,1,2,...,7,0 with a one-cycle idle gap between grants.
REQ-031 MAX_HOLD=4, req=8'b0000_1000 held constantly -> grant_idx=3 for 4 cycles, then timeout=1 with grant_valid=0 for 1 cycle, then grant_idx=3 again.
REQ-032 MAX_HOLD=4, req=8'b1000_0100 held, owner 2 times out -> the next grant_idx is 7, and after owner 7 times out, grant_idx returns to 2 through the wrap.
REQ-033 Owner 5 granted, then rst_n=0 for one edge -> grant=0, grant_valid=0, timeout=0 on that edge, and with req=8'h30 the next grant is grant_idx=4 (ptr=0).
REQ-034 Every cycle of every test -> $onehot0(grant) holds and grant_idx matches the encoding of grant.
